// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: shared types for the unified instruction/data memory arbiter
package rv32_mem_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
    localparam logic [3:0] BE_WORD = 4'hF;
endpackage

// File: rtl/rv32_mem_arb_pick.sv
// rv32_mem_arb_pick: data-priority winner selection with bounded fetch starvation
module rv32_mem_arb_pick
    import rv32_mem_pkg::*;
#(
    parameter int DATA_PRIO_MAX = 4
) (
    input  logic       if_req,
    input  logic       d_req,
    input  logic [3:0] streak,
    output owner_t     win
);
    always_comb win = (d_req && !(if_req && streak == 4'(DATA_PRIO_MAX))) ? OWN_D :
                      if_req ? OWN_IF : OWN_NONE;
endmodule

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one single-port memory between fetch and data ports, one transaction in flight
module rv32_mem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int DATA_PRIO_MAX  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_err,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_err,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    arb_state_t  state;
    owner_t      owner, win;
    logic [3:0]  streak;
    logic [31:0] timer;
    logic        done, to, resp;
    logic [31:0] rdata;

    rv32_mem_arb_pick #(.DATA_PRIO_MAX(DATA_PRIO_MAX)) u_pick (
        .if_req(if_req),
        .d_req (d_req),
        .streak(streak),
        .win   (win)
    );

    // a normal completion in the same cycle always beats the timeout
    assign done     = state == RESP && mem_rvalid;
    assign to       = TIMEOUT_CYCLES != 0 && state != IDLE && timer == 32'(TIMEOUT_CYCLES - 1) && !done;
    assign resp     = done || to;
    assign rdata    = done ? mem_rdata : '0;
    assign if_valid = resp && owner == OWN_IF;
    assign d_valid  = resp && owner == OWN_D;
    assign if_err   = if_valid && to;
    assign d_err    = d_valid && to;
    assign if_rdata = rdata;
    assign d_rdata  = rdata;
    assign if_stall = rst_n && if_req && !if_valid;
    assign d_stall  = rst_n && d_req && !d_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            streak    <= '0;
            timer     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            case (state)
                IDLE: if (win != OWN_NONE) begin
                    owner     <= win;
                    state     <= REQ;
                    timer     <= '0;
                    mem_req   <= 1'b1;
                    mem_we    <= win == OWN_D && d_we;
                    mem_addr  <= win == OWN_D ? d_addr : if_addr;
                    mem_wdata <= win == OWN_D ? d_wdata : '0;
                    mem_be    <= win == OWN_D ? d_be : BE_WORD;
                    streak    <= (win == OWN_D && if_req) ?
                                 (streak == 4'(DATA_PRIO_MAX) ? streak : streak + 4'd1) : '0;
                end
                REQ: begin
                    timer <= timer + 32'd1;
                    if (to) begin
                        mem_req <= 1'b0;
                        owner   <= OWN_NONE;
                        state   <= IDLE;
                    end else if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    timer <= timer + 32'd1;
                    if (resp) begin
                        owner <= OWN_NONE;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one single-port unified memory between the fetch-stage instruction port and the memory-stage data port.
- Replaces the separate code and data memory ports at the CPU boundary.
- Runs a three-state sequencer that keeps one transaction outstanding, returns responses to the owning requester, and drives per-port stall signals into pipeline hazard control.
- Arbitration: data has priority, with a bounded-starvation guarantee for fetch and a response timeout.

Parameters:
- DATA_PRIO_MAX, 4, maximum consecutive data grants while a fetch is pending before fetch is forced to win (1..15).
- TIMEOUT_CYCLES, 255, cycles allowed in REQ+RESP before the transaction is aborted with an error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetch data
- if_valid  out  1  fetch response pulse
- if_err  out  1  fetch aborted by timeout, qualified by if_valid
- if_stall  out  1  fetch waiting
- d_req  in  1  data request, held until d_valid
- d_we  in  1  1 = store
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_be  in  4  byte enables
- d_rdata  out  32  load data
- d_valid  out  1  data response pulse (loads and stores)
- d_err  out  1  data timeout, qualified by d_valid
- d_stall  out  1  data waiting
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  memory response, including store ack
- mem_rdata  in  32  memory read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, owner NONE, streak 0, timer 0, and all mem_* outputs 0. Response and stall outputs are combinational and are therefore 0 in reset.
- State IDLE:
  - If any request is present, pick a winner.
  - Latch owner, we, addr, wdata and be into registers.
  - For a fetch, latch mem_we=0 and mem_be=4'hF.
  - Set mem_req<=1 and go to REQ.
- Arbitration at the IDLE decision:
  - d_req alone → data wins. if_req alone → fetch wins.
  - Both requesting → data wins, unless streak==DATA_PRIO_MAX, in which case fetch wins.
  - streak increments on a data grant made while if_req=1. It clears on a fetch grant or on a data grant made while if_req=0. It saturates at DATA_PRIO_MAX.
- State REQ:
  - mem_* outputs are held stable.
  - On a cycle where mem_gnt=1: mem_req<=0, go to RESP.
- State RESP:
  - Wait for mem_rvalid=1.
  - In that same cycle, the owner's valid is driven combinationally and its rdata = mem_rdata, passed through.
  - Next state is IDLE.
  - A mem_rvalid arriving in any state other than RESP is ignored.
- Latency: minimum request-to-valid is 2 cycles (request seen in IDLE at T0, mem_gnt at T1, mem_rvalid at T2).
  - The requester may drop its request or present a new one from T3.
  - Back-to-back throughput is one transaction per 3 cycles.
- Stalls: if_stall = if_req & ~if_valid; d_stall = d_req & ~d_valid.
- Write data: the arbiter never modifies data. Unselected byte lanes of mem_wdata pass through unchanged.
- Timeout (TIMEOUT_CYCLES>0):
  - The timer clears on entry to REQ and increments in REQ and RESP.
  - When timer==TIMEOUT_CYCLES-1 and no completion occurs that cycle: pulse the owner's valid with err=1 and rdata=0, force mem_req<=0, go to IDLE.
  - A mem_rvalid that arrives later is ignored, because owner is NONE in IDLE.
- Simultaneous events:
  - mem_gnt and mem_rvalid in the same REQ cycle → only the grant is honoured (a single outstanding transaction is assumed).
  - A timeout and mem_rvalid in the same cycle → the normal response wins, err=0.
- Requester dropping its request before valid: the transaction still completes, the response pulse is still generated, and stall follows the request.
- Reset asserted mid-transaction: everything returns to IDLE immediately and no response is produced for the lost transaction. The memory must be reset alongside the arbiter.

Decomposition:
- Package rv32_mem_pkg holds:
  - typedef enum arb_state_t {IDLE, REQ, RESP}
  - typedef enum owner_t {OWN_NONE, OWN_IF, OWN_D}
  - localparam BE_WORD = 4'hF
- One combinational sub-module, rv32_mem_arb_pick. Inputs: if_req, d_req, streak, DATA_PRIO_MAX. Output: the winning owner. It is verified standalone.

Test Plan:
- Single fetch: if_req=1 at 0x100, mem_gnt at T1, mem_rvalid with 0xDEADBEEF at T2 → if_valid=1 and if_rdata=0xDEADBEEF at T2, mem_addr=0x100, mem_be=4'hF, mem_we=0.
- Store: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0x12345678, d_be=4'b0011 → mem_* carry exactly these values in REQ, d_valid pulses on the ack, d_rdata is don't-care.
- Contention with DATA_PRIO_MAX=4 and both requests held continuously → grant order D,D,D,D,IF,D,D,D,D,IF; if_stall stays high between the fetch grants.
- Memory delays mem_gnt by 5 cycles, then mem_rvalid by 7 cycles → mem_* stable throughout REQ, d_stall high, a single d_valid pulse, no duplicate mem_req.
- TIMEOUT_CYCLES=8 and memory never responds → d_valid=1 and d_err=1 exactly 8 cycles after REQ entry, d_rdata=0; a stray mem_rvalid one cycle later produces no pulse.
- rst_n pulsed low during RESP → outputs zero asynchronously, no valid pulse; after release a fresh if_req completes normally with streak=0.
